// File: rtl/cordic_hyp_iter_engine.sv
// cordic_hyp_iter_engine
// Iterative hyperbolic CORDIC engine, signed Q2.14 by default. One micro-rotation
// is performed per clock. The atanh(2^-i) constants live in an external table
// that is addressed through angle_idx and answers combinationally on angle_in.
// The shift sequence is 1,2,3,4,4,5,...,ITERATIONS. Index 4 is repeated so that
// the hyperbolic iteration converges.
// Compile option: CORDIC_HYP_GAIN_COMP_EN inserts a GAIN state after RUN. That
// state scales x and y by 1/K_h, which adds one cycle of latency.
module cordic_hyp_iter_engine #(
    parameter int FIXED_WIDTH = 16,
    parameter int ITERATIONS  = 9
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          mode,
    input  logic [FIXED_WIDTH-1:0]        x_in,
    input  logic [FIXED_WIDTH-1:0]        y_in,
    input  logic [FIXED_WIDTH-1:0]        z_in,
    output logic [$clog2(ITERATIONS)-1:0] angle_idx,
    input  logic [FIXED_WIDTH-1:0]        angle_in,
    output logic                          busy,
    output logic                          done,
    output logic [FIXED_WIDTH-1:0]        x_out,
    output logic [FIXED_WIDTH-1:0]        y_out,
    output logic [FIXED_WIDTH-1:0]        z_out
);

    localparam int IDX_W  = $clog2(ITERATIONS);
    localparam int STEP_W = $clog2(ITERATIONS + 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(ITERATIONS);

`ifdef CORDIC_HYP_GAIN_COMP_EN
    // Fraction bits of the Q2.x format, and the matching 1/K_h constant (19784 in Q2.14).
    localparam int FRAC_W = FIXED_WIDTH - 2;
    localparam int PROD_W = 2 * FIXED_WIDTH + 2;
    localparam logic signed [PROD_W-1:0] GAIN_RECIP = PROD_W'(32'sd19784);
    localparam logic signed [PROD_W-1:0] ROUND_HALF = PROD_W'(64'sd1) <<< (FRAC_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAIN = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1
    } state_t;
`endif

    state_t state_q, state_d;

    logic [STEP_W-1:0]             step_q, step_d;
    logic                          mode_q, mode_d;
    logic signed [FIXED_WIDTH-1:0] x_q, x_d;
    logic signed [FIXED_WIDTH-1:0] y_q, y_d;
    logic signed [FIXED_WIDTH-1:0] z_q, z_d;
    logic [IDX_W-1:0]              angle_idx_q, angle_idx_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic [FIXED_WIDTH-1:0]        x_out_q, x_out_d;
    logic [FIXED_WIDTH-1:0]        y_out_q, y_out_d;
    logic [FIXED_WIDTH-1:0]        z_out_q, z_out_d;

    // Micro-rotation datapath signals
    logic signed [FIXED_WIDTH-1:0] x_sh_s;
    logic signed [FIXED_WIDTH-1:0] y_sh_s;
    logic signed [FIXED_WIDTH-1:0] ang_s;
    logic                          dir_pos_s;
    logic signed [FIXED_WIDTH-1:0] x_step_s;
    logic signed [FIXED_WIDTH-1:0] y_step_s;
    logic signed [FIXED_WIDTH-1:0] z_step_s;

    // Maps a step number to its shift index. Steps 0..3 use shifts 1..4. From
    // step 4 onward the shift equals the step number, which repeats shift 4.
    function automatic logic [IDX_W-1:0] shift_of(input logic [STEP_W-1:0] s);
        logic [IDX_W-1:0] r;
        if (s < STEP_W'(32'd4)) begin
            r = IDX_W'(s) + IDX_W'(32'd1);
        end else begin
            r = IDX_W'(s);
        end
        return r;
    endfunction

`ifdef CORDIC_HYP_GAIN_COMP_EN
    // Multiplies by 1/K_h, rounds to nearest (half up), and wraps to the data width.
    function automatic logic [FIXED_WIDTH-1:0] gain_scale(input logic signed [FIXED_WIDTH-1:0] v);
        logic signed [PROD_W-1:0] prod;
        prod = PROD_W'(v) * GAIN_RECIP + ROUND_HALF;
        return FIXED_WIDTH'(prod >>> FRAC_W);
    endfunction
`endif

    // State and datapath registers; asynchronous reset clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            step_q      <= '0;
            mode_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            angle_idx_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            x_out_q     <= '0;
            y_out_q     <= '0;
            z_out_q     <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            mode_q      <= mode_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            angle_idx_q <= angle_idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            x_out_q     <= x_out_d;
            y_out_q     <= y_out_d;
            z_out_q     <= z_out_d;
        end
    end

    // One hyperbolic micro-rotation, using the current shift and the returned table angle.
    always_comb begin
        x_sh_s = x_q >>> angle_idx_q;
        y_sh_s = y_q >>> angle_idx_q;
        ang_s  = $signed(angle_in);
        if (mode_q) begin
            dir_pos_s = y_q[FIXED_WIDTH-1];
        end else begin
            dir_pos_s = ~z_q[FIXED_WIDTH-1];
        end
        if (dir_pos_s) begin
            x_step_s = x_q + y_sh_s;
            y_step_s = y_q + x_sh_s;
            z_step_s = z_q - ang_s;
        end else begin
            x_step_s = x_q - y_sh_s;
            y_step_s = y_q - x_sh_s;
            z_step_s = z_q + ang_s;
        end
    end

    // Next-state logic: IDLE -> RUN for ITERATIONS+1 steps -> (GAIN) -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (step_q == LAST_STEP) begin
`ifdef CORDIC_HYP_GAIN_COMP_EN
                    state_d = ST_GAIN;
`else
                    state_d = ST_IDLE;
`endif
                end else begin
                    state_d = ST_RUN;
                end
            end
`ifdef CORDIC_HYP_GAIN_COMP_EN
            ST_GAIN: begin
                state_d = ST_IDLE;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output and datapath next values. The result registers hold until the next completion.
    always_comb begin
        step_d  = step_q;
        mode_d  = mode_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        done_d  = 1'b0;
        x_out_d = x_out_q;
        y_out_d = y_out_q;
        z_out_d = z_out_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d = mode;
                    x_d    = $signed(x_in);
                    y_d    = $signed(y_in);
                    z_d    = $signed(z_in);
                    step_d = '0;
                end else begin
                    step_d = '0;
                end
            end
            ST_RUN: begin
                x_d = x_step_s;
                y_d = y_step_s;
                z_d = z_step_s;
                if (step_q == LAST_STEP) begin
                    step_d = '0;
`ifndef CORDIC_HYP_GAIN_COMP_EN
                    x_out_d = x_step_s;
                    y_out_d = y_step_s;
                    z_out_d = z_step_s;
                    done_d  = 1'b1;
`endif
                end else begin
                    step_d = step_q + STEP_W'(32'd1);
                end
            end
`ifdef CORDIC_HYP_GAIN_COMP_EN
            ST_GAIN: begin
                x_out_d = gain_scale(x_q);
                y_out_d = gain_scale(y_q);
                z_out_d = z_q;
                done_d  = 1'b1;
            end
`endif
            default: begin
                step_d = '0;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        if (state_d == ST_RUN) begin
            angle_idx_d = shift_of(step_d);
        end else begin
            angle_idx_d = '0;
        end
    end

    assign angle_idx = angle_idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign x_out     = x_out_q;
    assign y_out     = y_out_q;
    assign z_out     = z_out_q;

endmodule

// File: tb/tb_cordic_hyp_iter_engine.sv
// Self-checking bench for cordic_hyp_iter_engine. It uses an independent reference
// model and a queue scoreboard. It honours CORDIC_HYP_GAIN_COMP_EN.
module tb_cordic_hyp_iter_engine;
    localparam int W    = 16;
    localparam int ITER = 9;
    localparam int IW   = $clog2(ITER);
`ifdef CORDIC_HYP_GAIN_COMP_EN
    localparam int LAT  = ITER + 2;
`else
    localparam int LAT  = ITER + 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mode;
    logic [W-1:0]  x_in, y_in, z_in;
    logic [IW-1:0] angle_idx;
    logic [W-1:0]  angle_in;
    logic          busy, done;
    logic [W-1:0]  x_out, y_out, z_out;

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] z;
    } res_t;

    res_t exp_q[$];
    int   idx_seen[$];
    int   tests = 0;
    int   fails = 0;

    cordic_hyp_iter_engine #(.FIXED_WIDTH(W), .ITERATIONS(ITER)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .angle_idx(angle_idx), .angle_in(angle_in),
        .busy(busy), .done(done),
        .x_out(x_out), .y_out(y_out), .z_out(z_out)
    );

    always #5 clk = ~clk;

    // atanh(2^-i) in Q2.14, rounded to nearest
    function automatic logic [W-1:0] atanh_lut(input int i);
        case (i)
            1: return 16'd9000;
            2: return 16'd4185;
            3: return 16'd2059;
            4: return 16'd1025;
            5: return 16'd512;
            6: return 16'd256;
            7: return 16'd128;
            8: return 16'd64;
            9: return 16'd32;
            default: return 16'd0;
        endcase
    endfunction

    always_comb angle_in = atanh_lut(int'(angle_idx));

    function automatic logic [W-1:0] gain_ref(input logic signed [W-1:0] v);
        longint p;
        p = longint'(v) * 64'sd19784 + 64'sd8192;
        return W'(p >>> 14);
    endfunction

    // Reference hyperbolic CORDIC computed step by step.
    function automatic res_t model(input logic m, input logic [W-1:0] xi, input logic [W-1:0] yi,
                                   input logic [W-1:0] zi);
        logic signed [W-1:0] x, y, z, xn, yn, zn, a;
        int sh;
        bit pos;
        res_t r;
        x = xi; y = yi; z = zi;
        for (int s = 0; s <= ITER; s++) begin
            sh = (s < 4) ? s + 1 : s;
            a  = atanh_lut(sh);
            pos = m ? (y < 0) : (z >= 0);
            if (pos) begin
                xn = x + (y >>> sh); yn = y + (x >>> sh); zn = z - a;
            end else begin
                xn = x - (y >>> sh); yn = y - (x >>> sh); zn = z + a;
            end
            x = xn; y = yn; z = zn;
        end
`ifdef CORDIC_HYP_GAIN_COMP_EN
        x = gain_ref(x);
        y = gain_ref(y);
`endif
        r.x = x; r.y = y; r.z = z;
        return r;
    endfunction

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_tol(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv,
                             input logic signed [63:0] tol);
        logic signed [63:0] diff;
        diff = obs - expv;
        if (diff < 0) diff = -diff;
        tests++;
        assert (diff <= tol) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, expv, tol);
        end
    endtask

    // Drives a start at the current negedge and predicts the result.
    task automatic launch(input logic m, input logic [W-1:0] xi, input logic [W-1:0] yi,
                          input logic [W-1:0] zi);
        mode = m; x_in = xi; y_in = yi; z_in = zi; start = 1'b1;
        exp_q.push_back(model(m, xi, yi, zi));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for done and checks latency, handshake and the scoreboard entry.
    // Optionally re-pulses start with different operands on busy cycle restart_at+1.
    task automatic wait_done(input string tag, input int restart_at);
        int   cyc;
        res_t e;
        cyc = 0;
        idx_seen.delete();
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1 && cyc <= ITER) idx_seen.push_back(int'(angle_idx));
            if (cyc == restart_at) begin
                start = 1'b1; mode = ~mode; x_in = 16'h1234; y_in = 16'h0F0F; z_in = 16'hC000;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, "_latency"}, cyc, LAT);
        check({tag, "_busy_at_done"}, busy, 1'b0);
        if (done === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_x"}, $signed(x_out), $signed(e.x));
            check({tag, "_y"}, $signed(y_out), $signed(e.y));
            check({tag, "_z"}, $signed(z_out), $signed(e.z));
        end else begin
            check({tag, "_done_seen"}, done, 1'b1);
        end
    endtask

    initial begin
        int exp_idx[10];
        int done_cnt;
        exp_idx = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9};
        rst = 1'b1; start = 1'b0; mode = 1'b0;
        x_in = 16'h0000; y_in = 16'h0000; z_in = 16'h0000;

        // Reset state
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_idx", angle_idx, 4'd0);
        check("rst_xyz", {x_out, y_out, z_out}, 48'd0);

        // Start accepted on the first edge after reset release; rotation by 0.5
        @(negedge clk);
        rst = 1'b0;
        launch(1'b0, 16'h4000, 16'h0000, 16'h2000);
        wait_done("rot", -1);
        check("idx_count", idx_seen.size(), 10);
        for (int k = 0; k < 10 && k < idx_seen.size(); k++) begin
            check($sformatf("idx_step%0d", k), idx_seen[k], exp_idx[k]);
        end
`ifdef CORDIC_HYP_GAIN_COMP_EN
        check_tol("rot_cosh", $signed(x_out), 64'sh482B, 64'sd4);
        check_tol("rot_sinh", $signed(y_out), 64'sh215A, 64'sd4);
`else
        check_tol("rot_kcosh", $signed(x_out), 64'sh3BC4, 64'sd8);
        check_tol("rot_ksinh", $signed(y_out), 64'sh1BA0, 64'sd8);
`endif
        check_tol("rot_zres", $signed(z_out), 64'sd0, 64'sh40);
        @(negedge clk);
        check("done_one_cycle", done, 1'b0);
        check("idle_idx", angle_idx, 4'd0);

        // Vectoring: atanh(0.5)
        launch(1'b1, 16'h4000, 16'h2000, 16'h0000);
        wait_done("vec", -1);
        check_tol("vec_atanh", $signed(z_out), 64'sh2328, 64'sh40);
        check_tol("vec_yres", $signed(y_out), 64'sd0, 64'sh40);
        @(negedge clk);

        // Start during busy is ignored; then a back-to-back start in the done cycle
        launch(1'b0, 16'h3000, 16'h0800, 16'hE800);
        wait_done("ignore", 2);
        check("ignore_queue_empty", exp_q.size(), 0);
        launch(1'b1, 16'h5000, 16'hF000, 16'h0100);
        wait_done("b2b", -1);
        @(negedge clk);

        // Assorted in-range operands plus one out-of-range case
        for (int n = 0; n < 4; n++) begin
            logic [W-1:0] xr, yr, zr;
            xr = W'($urandom_range(16'h2800, 16'h5000));
            yr = W'(int'($urandom_range(0, 16'h1000)) - 16'h0800);
            zr = W'(int'($urandom_range(0, 36000)) - 18000);
            launch(n[0], xr, yr, zr);
            wait_done($sformatf("rand%0d", n), -1);
            @(negedge clk);
        end
        launch(1'b0, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        wait_done("out_of_range", -1);
        @(negedge clk);

        // Reset at step 5 aborts without a done pulse
        launch(1'b0, 16'h4000, 16'h0000, 16'h1000);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_idx", angle_idx, 4'd0);
        check("abort_xyz", {x_out, y_out, z_out}, 48'd0);
        void'(exp_q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        done_cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        launch(1'b1, 16'h4800, 16'h1000, 16'h0000);
        wait_done("after_abort", -1);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cordic_hyp_iter_engine.md
CORDIC_HYP_ITER_ENGINE -- requirements
Module: cordic_hyp_iter_engine

Interface
REQ-001 SHALL have parameter FIXED_WIDTH, default 16: data/angle width, signed Q2.14.
REQ-002 SHALL have parameter ITERATIONS, default 9: highest shift index used; the table index bus width is $clog2(ITERATIONS).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port mode  input  1  0 = rotation, 1 = vectoring; captured with start.
REQ-007 SHALL have ports x_in, y_in, z_in  input  FIXED_WIDTH each  signed operands; captured with start.
REQ-008 SHALL have port angle_idx  output  $clog2(ITERATIONS)  index presented to the external atanh table.
REQ-009 SHALL have port angle_in  input  FIXED_WIDTH  signed atanh(2^-angle_idx), combinational return from the table in the same cycle.
REQ-010 SHALL have port busy  output  1  high while iterating.
REQ-011 SHALL have port done  output  1  one-cycle pulse when results are valid.
REQ-012 SHALL have ports x_out, y_out, z_out  output  FIXED_WIDTH each  registered signed results, held until next done.

Function
REQ-013 SHALL implement FSM IDLE -> RUN -> (GAIN when REQ-028 is enabled) -> IDLE; start=1 in IDLE loads x, y, z and mode, sets step=0 and enters RUN.
REQ-014 SHALL perform one micro-iteration per RUN cycle over shift sequence 1,2,3,4,4,5,...,ITERATIONS: index 4 is repeated once. This gives ITERATIONS+1 steps (10 at the default).
REQ-015 SHALL drive angle_idx with the current step's shift index during RUN, and 0 in IDLE.
REQ-016 Rotation: d=+1 if z>=0, else -1.
REQ-017 Vectoring: d=+1 if y<0, else -1.
REQ-018 Each step SHALL compute x'=x+d*(y>>>i), y'=y+d*(x>>>i), z'=z-d*angle_in. Shifts are arithmetic, sums truncate/wrap to FIXED_WIDTH, and all updates happen simultaneously.
REQ-019 Without REQ-028, the last RUN step SHALL load x_out, y_out, z_out and assert done on the same edge. Latency from the start-sampling edge to done high is exactly ITERATIONS+1 cycles.
REQ-020 busy SHALL rise on the edge that samples start and fall on the edge that raises done.
REQ-021 done SHALL be high for exactly one cycle; the FSM SHALL be back in IDLE during that cycle, so start may be accepted in the done cycle.
REQ-022 start while busy SHALL be ignored: no restart, operands unchanged.
REQ-023 Inputs SHALL be valid only within the convergence range |z_in|<=1.118 (rotation) and x_in>|y_in| (vectoring); outside that range results are unspecified but SHALL still complete with normal latency and handshake.

Reset
REQ-024 On rst high: FSM=IDLE, busy=0, done=0, angle_idx=0, x_out=y_out=z_out=0, internal x/y/z/step=0.
REQ-025 rst asserted mid-operation SHALL abort immediately; no done pulse SHALL follow.
REQ-026 The first start SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-027 Macro CORDIC_HYP_GAIN_COMP_EN SHALL be the only compile option.
REQ-028 When CORDIC_HYP_GAIN_COMP_EN is defined:
- state GAIN follows RUN and multiplies x and y by 1/K_h = 19784 (Q2.14, ~1.2075), rounding to nearest and truncating to FIXED_WIDTH;
- z passes through unchanged;
- done is asserted at the GAIN exit, so latency = ITERATIONS+2.
REQ-029 When CORDIC_HYP_GAIN_COMP_EN is undefined: no GAIN state, no multiplier, raw outputs, latency = ITERATIONS+1.

Verification
REQ-030 angle_idx sequence: rotation, start -> angle_idx over RUN = 1,2,3,4,4,5,6,7,8,9; done exactly 10 cycles after start (11 with comp).
REQ-031 Rotation with comp: x_in=0x4000, y_in=0, z_in=0x2000 -> x_out=0x482B±4 (cosh 0.5), y_out=0x215A±4 (sinh 0.5), z_out within ±0x0040 of 0.
REQ-032 Rotation without comp, same stimulus -> x_out=0x3BC4±8 (K_h*cosh 0.5), y_out≈0x1BA0±8.
REQ-033 Vectoring: mode=1, x_in=0x4000, y_in=0x2000, z_in=0 -> z_out=0x2328±0x40 (atanh 0.5), y_out within ±0x0040 of 0.
REQ-034 Protocol: start re-pulsed on cycle 3 of busy -> ignored, single done, results match the first request. A back-to-back start in the done cycle is accepted.
REQ-035 Reset mid-op: rst pulse at step 5 -> busy=0, outputs=0, no done; a new start afterwards completes normally.
